// File: rtl/monochr_pkg.sv
// Shared definitions for the monochrome CCD line readout: sequencer state
// encoding, ADC word width, default timing and the dark-offset helper.
package monochr_pkg;

   localparam int CCD_DATA_W  = 11;

   localparam int DEF_CLK_DIV = 4;
   localparam int DEF_PIXELS  = 2048;
   localparam int DEF_ROG_LEN = 8;
   localparam int DEF_GAP_LEN = 4;
   localparam int DEF_DARK    = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ROG  = 3'd1,
      ST_GAP  = 3'd2,
      ST_READ = 3'd3,
      ST_DONE = 3'd4
   } ccd_state_t;

   // Dark-offset removal clamped at zero; the compare happens before the
   // subtraction so an 11-bit result can never wrap.
   function automatic logic [CCD_DATA_W-1:0] dark_sub(
      input logic [CCD_DATA_W-1:0] raw,
      input logic [CCD_DATA_W-1:0] dark
   );
      return (raw > dark) ? (raw - dark) : '0;
   endfunction

endpackage

// File: rtl/ccd_phase_gen.sv
// Pixel-period phase generator: one pixel period is 2*CLK_DIV system clocks,
// clk_ccd high for the first half, clk_adc high for the second half.
// Both clocks come straight from flops so they cannot glitch.
module ccd_phase_gen
   import monochr_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
)(
   input  logic CLK,
   input  logic RESET,
   input  logic run,
   input  logic run_nxt,
   output logic clk_ccd,
   output logic clk_adc,
   output logic sample_tick
);

   localparam int PERIOD = 2 * CLK_DIV;
   localparam int PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [PW-1:0] PH_LAST = PW'(PERIOD - 1);
   localparam logic [PW-1:0] PH_HALF = PW'(CLK_DIV);

   logic [PW-1:0] phase;
   logic [PW-1:0] phase_nxt;
   logic          ccd_hi_nxt;

   // Next phase: restarts at 0 on entry to READ and wraps at the period end.
   always_comb begin
      phase_nxt = '0;
      if (run && run_nxt && (phase != PH_LAST)) begin
         phase_nxt = phase + PW'(1);
      end
      ccd_hi_nxt = (phase_nxt < PH_HALF);
   end

   // Sample on the last system clock of the pixel period, when ADC data is valid.
   assign sample_tick = run && (phase == PH_LAST);

   // Phase register and registered CCD/ADC clocks, derived from the next phase
   // so the output level lines up with the phase it belongs to.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         phase   <= '0;
         clk_ccd <= 1'b0;
         clk_adc <= 1'b0;
      end else begin
         phase   <= phase_nxt;
         clk_ccd <= run_nxt && ccd_hi_nxt;
         clk_adc <= run_nxt && !ccd_hi_nxt;
      end
   end

endmodule

// File: rtl/ccd_readout.sv
// Single-line CCD readout sequencer: read-out-gate pulse, settle gap, pixel
// shifting with ADC sampling, dark-offset correction and line-memory writes.
//
// state | meaning
// IDLE  | waiting for start, all CCD drive low
// ROG   | rog_ccd high, charge transfer into the shift register
// GAP   | everything low, settle before the first pixel clock
// READ  | pixel clocking; one sample and one write per pixel period
// DONE  | last write and line_done pulse, back to IDLE next cycle
module ccd_readout
   import monochr_pkg::*;
#(
   parameter int  CLK_DIV = DEF_CLK_DIV,
   parameter int  PIXELS  = DEF_PIXELS,
   parameter int  ROG_LEN = DEF_ROG_LEN,
   parameter int  GAP_LEN = DEF_GAP_LEN,
   parameter int  DARK    = DEF_DARK,
   localparam int AW      = (PIXELS > 1) ? $clog2(PIXELS) : 1
)(
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  start,
   input  logic [CCD_DATA_W-1:0] ccd_data,
   output logic                  clk_ccd,
   output logic                  rog_ccd,
   output logic                  clk_adc,
   output logic                  pix_we,
   output logic [AW-1:0]         pix_addr,
   output logic [CCD_DATA_W-1:0] pix_data,
   output logic                  busy,
   output logic                  line_done
);

   localparam int CNT_MAX = (ROG_LEN > GAP_LEN) ? ROG_LEN : GAP_LEN;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0]      ROG_LOAD = CNT_W'(ROG_LEN - 1);
   localparam logic [CNT_W-1:0]      GAP_LOAD = CNT_W'(GAP_LEN - 1);
   localparam logic [AW-1:0]         PIX_LAST = AW'(PIXELS - 1);
   localparam logic [CCD_DATA_W-1:0] DARK_W   = CCD_DATA_W'(DARK);

   ccd_state_t       state;
   ccd_state_t       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [AW-1:0]    pixel;
   logic             sample_tick;
   logic             last_pixel;

   assign last_pixel = sample_tick && (pixel == PIX_LAST);

   ccd_phase_gen #(
      .CLK_DIV     (CLK_DIV)
   ) u_phase_gen (
      .CLK         (CLK),
      .RESET       (RESET),
      .run         (state == ST_READ),
      .run_nxt     (state_nxt == ST_READ),
      .clk_ccd     (clk_ccd),
      .clk_adc     (clk_adc),
      .sample_tick (sample_tick)
   );

   // Next-state logic; start is only looked at in IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start)          state_nxt = ST_ROG;
         ST_ROG:  if (cnt == '0)      state_nxt = ST_GAP;
         ST_GAP:  if (cnt == '0)      state_nxt = ST_READ;
         ST_READ: if (last_pixel)     state_nxt = ST_DONE;
         ST_DONE:                     state_nxt = ST_IDLE;
         default:                     state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ROG/GAP length timer: loaded with LEN-1 on entry, leaves at terminal count 0.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt <= '0;
      end else if (state_nxt != state) begin
         if (state_nxt == ST_ROG) begin
            cnt <= ROG_LOAD;
         end else if (state_nxt == ST_GAP) begin
            cnt <= GAP_LOAD;
         end else begin
            cnt <= '0;
         end
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   // Pixel index: held at 0 outside READ, advances after every sample.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pixel <= '0;
      end else if (state != ST_READ) begin
         pixel <= '0;
      end else if (sample_tick) begin
         pixel <= pixel + AW'(1);
      end
   end

   // Registered sequencer outputs, taken from the next state so they are
   // aligned with the state they describe.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rog_ccd   <= 1'b0;
         busy      <= 1'b0;
         line_done <= 1'b0;
      end else begin
         rog_ccd   <= (state_nxt == ST_ROG);
         busy      <= (state_nxt != ST_IDLE);
         line_done <= (state_nxt == ST_DONE);
      end
   end

   // Line-memory write port: one cycle after each sample, dark-corrected value.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pix_we   <= 1'b0;
         pix_addr <= '0;
         pix_data <= '0;
      end else begin
         pix_we <= sample_tick;
         if (sample_tick) begin
            pix_addr <= pixel;
            pix_data <= dark_sub(ccd_data, DARK_W);
         end
      end
   end

endmodule

// File: tb/tb_ccd_readout.sv
// Bench for ccd_readout with a small line (8 pixels, 4-clock pixel period).
// Outputs are logged every cycle at the falling edge and compared against a
// timeline computed from the start cycle with plain arithmetic.
module tb_ccd_readout;

   localparam int CD       = 2;
   localparam int PIX      = 8;
   localparam int RL       = 4;
   localparam int GL       = 2;
   localparam int DK       = 16;
   localparam int PER      = 2 * CD;
   localparam int RS_OFF   = 1 + RL + GL;
   localparam int LINE_END = RS_OFF + PIX * PER;
   localparam int LOG_N    = 4096;

   logic        CLK      = 1'b0;
   logic        RESET    = 1'b0;
   logic        start    = 1'b0;
   logic [10:0] ccd_data = '0;
   logic        clk_ccd;
   logic        rog_ccd;
   logic        clk_adc;
   logic        pix_we;
   logic [2:0]  pix_addr;
   logic [10:0] pix_data;
   logic        busy;
   logic        line_done;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int cur    = 0;

   int          dmode  = 0;
   logic [10:0] dconst = '0;
   int          dline  = 0;
   logic [10:0] dtab    [0:PIX-1];
   logic [10:0] sat_exp [0:PIX-1];

   logic [5:0]  lg_ctrl [0:LOG_N-1];
   logic [2:0]  lg_addr [0:LOG_N-1];
   logic [10:0] lg_data [0:LOG_N-1];
   logic [10:0] drv     [0:LOG_N-1];

   ccd_readout #(
      .CLK_DIV   (CD),
      .PIXELS    (PIX),
      .ROG_LEN   (RL),
      .GAP_LEN   (GL),
      .DARK      (DK)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .start     (start),
      .ccd_data  (ccd_data),
      .clk_ccd   (clk_ccd),
      .rog_ccd   (rog_ccd),
      .clk_adc   (clk_adc),
      .pix_we    (pix_we),
      .pix_addr  (pix_addr),
      .pix_data  (pix_data),
      .busy      (busy),
      .line_done (line_done)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Dark correction from the arithmetic rule.
   function automatic logic [10:0] model_pix(input logic [10:0] raw);
      int v;
      v = int'(raw) - DK;
      if (v < 0) v = 0;
      return 11'(v);
   endfunction

   // Expected {rog, clk_ccd, clk_adc, pix_we, busy, line_done} in cycle c for a
   // line whose start pulse was high in cycle s.
   function automatic logic [5:0] model_ctrl(input int c, input int s);
      int   off;
      logic rd, rog, ck, adc, we, bsy, dn;
      off = c - (s + RS_OFF);
      rd  = (off >= 0) && (off < PIX * PER);
      rog = (c >= s + 1) && (c <= s + RL);
      ck  = rd && ((off % PER) < CD);
      adc = rd && ((off % PER) >= CD);
      we  = (off >= PER) && (off <= PIX * PER) && ((off % PER) == 0);
      bsy = (c >= s + 1) && (off <= PIX * PER);
      dn  = (off == PIX * PER);
      return {rog, ck, adc, we, bsy, dn};
   endfunction

   function automatic logic [10:0] pick_data(input int c);
      int k;
      case (dmode)
         1: return dconst;
         2: begin
            k = (c - dline - RS_OFF) / PER;
            if (k < 0) k = 0;
            if (k > PIX - 1) k = PIX - 1;
            return dtab[k];
         end
         default: return 11'($urandom_range(0, 2047));
      endcase
   endfunction

   // One cycle: log this cycle's outputs, then drive this cycle's inputs.
   task automatic step(input logic st);
      @(negedge CLK);
      cur = cyc;
      if (cur >= LOG_N) begin
         $display("FAIL log_overflow: cycle %0d beyond limit %0d", cur, LOG_N);
         $fatal(1, "cycle log exhausted");
      end
      lg_ctrl[cur] = {rog_ccd, clk_ccd, clk_adc, pix_we, busy, line_done};
      lg_addr[cur] = pix_addr;
      lg_data[cur] = pix_data;
      start        = st;
      ccd_data     = pick_data(cur);
      drv[cur]     = ccd_data;
   endtask

   task automatic test_reset;
      #1 RESET = 1'b1;
      #1;
      checks++;
      if ({rog_ccd, clk_ccd, clk_adc, pix_we, busy, line_done} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 000000",
                  {rog_ccd, clk_ccd, clk_adc, pix_we, busy, line_done});
      end
      checks++;
      if (pix_addr !== 3'd0 || pix_data !== 11'd0) begin
         errors++;
         $display("FAIL reset_port: got addr %0d data %0h expected 0 0", pix_addr, pix_data);
      end
      repeat (3) step(1'b0);
      RESET = 1'b0;
      repeat (3) step(1'b0);
      checks++;
      if (lg_ctrl[cur] !== 6'b0) begin
         errors++;
         $display("FAIL reset_idle: got %b expected 000000", lg_ctrl[cur]);
      end
   endtask

   task automatic test_line_timing;
      int s, nwe, ndone;
      logic [5:0] ex;
      dmode = 1; dconst = 11'h0ff;
      step(1'b0);
      step(1'b1); s = cur; dline = s;
      for (int i = 1; i <= LINE_END + 4; i++) step(1'b0);
      nwe = 0; ndone = 0;
      for (int c = s; c <= s + LINE_END + 3; c++) begin
         ex = model_ctrl(c, s);
         checks++;
         if (lg_ctrl[c] !== ex) begin
            errors++;
            $display("FAIL line_ctrl cyc+%0d: got %b expected %b", c - s, lg_ctrl[c], ex);
         end
         if (lg_ctrl[c][2]) begin
            checks++;
            if (lg_addr[c] !== 3'(nwe) || lg_data[c] !== 11'h0ef) begin
               errors++;
               $display("FAIL line_write %0d: got addr %0d data %0h expected addr %0d data 0ef",
                        nwe, lg_addr[c], lg_data[c], nwe);
            end
            nwe++;
         end
         if (lg_ctrl[c][0]) ndone++;
      end
      checks++;
      if (nwe != PIX || ndone != 1) begin
         errors++;
         $display("FAIL line_counts: got %0d writes %0d done expected %0d 1", nwe, ndone, PIX);
      end
   endtask

   task automatic test_saturation;
      int s, nwe;
      dtab    = '{11'd10, 11'd16, 11'd17, 11'h7ff, 11'd15, 11'd0, 11'd1000, 11'h011};
      sat_exp = '{11'd0,  11'd0,  11'd1,  11'h7ef, 11'd0,  11'd0, 11'd984,  11'd1};
      dmode = 2;
      step(1'b0);
      step(1'b1); s = cur; dline = s;
      for (int i = 1; i <= LINE_END + 2; i++) step(1'b0);
      nwe = 0;
      for (int c = s; c <= s + LINE_END + 2; c++) begin
         if (lg_ctrl[c][2]) begin
            checks++;
            if (nwe >= PIX || lg_data[c] !== sat_exp[nwe % PIX]) begin
               errors++;
               $display("FAIL sat_data pixel %0d: got %0h expected %0h",
                        nwe, lg_data[c], sat_exp[nwe % PIX]);
            end
            nwe++;
         end
      end
      checks++;
      if (nwe != PIX) begin
         errors++;
         $display("FAIL sat_count: got %0d writes expected %0d", nwe, PIX);
      end
   endtask

   task automatic test_random_data;
      int s, nwe;
      logic [5:0] ex;
      dmode = 0;
      for (int ln = 0; ln < 2; ln++) begin
         repeat ($urandom_range(1, 5)) step(1'b0);
         step(1'b1); s = cur;
         for (int i = 1; i <= LINE_END + 2; i++) step(1'b0);
         nwe = 0;
         for (int c = s; c <= s + LINE_END + 2; c++) begin
            ex = model_ctrl(c, s);
            checks++;
            if (lg_ctrl[c] !== ex) begin
               errors++;
               $display("FAIL rand_ctrl line %0d cyc+%0d: got %b expected %b", ln, c - s, lg_ctrl[c], ex);
            end
            if (ex[2]) begin
               checks++;
               if (lg_addr[c] !== 3'(nwe) || lg_data[c] !== model_pix(drv[c-1])) begin
                  errors++;
                  $display("FAIL rand_write line %0d pixel %0d: got addr %0d data %0h expected addr %0d data %0h",
                           ln, nwe, lg_addr[c], lg_data[c], nwe, model_pix(drv[c-1]));
               end
               nwe++;
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      int s, nwe, ndone;
      logic [5:0] ex;
      dmode = 0;
      step(1'b0);
      step(1'b1); s = cur;
      for (int i = 1; i <= 2 * LINE_END + 6; i++)
         step((i == 2) || (i == 15) || (i == LINE_END) || (i == LINE_END + 1));
      nwe = 0; ndone = 0;
      for (int c = s; c <= s + 2 * LINE_END + 5; c++) begin
         ex = model_ctrl(c, s) | model_ctrl(c, s + LINE_END + 1);
         checks++;
         if (lg_ctrl[c] !== ex) begin
            errors++;
            $display("FAIL b2b_ctrl cyc+%0d: got %b expected %b", c - s, lg_ctrl[c], ex);
         end
         if (lg_ctrl[c][2]) begin
            checks++;
            if (lg_addr[c] !== 3'(nwe % PIX) || lg_data[c] !== model_pix(drv[c-1])) begin
               errors++;
               $display("FAIL b2b_write %0d: got addr %0d data %0h expected addr %0d data %0h",
                        nwe, lg_addr[c], lg_data[c], nwe % PIX, model_pix(drv[c-1]));
            end
            nwe++;
         end
         if (lg_ctrl[c][0]) ndone++;
         if (c == s + LINE_END) begin
            checks++;
            if (nwe != PIX) begin
               errors++;
               $display("FAIL b2b_first_line: got %0d writes expected %0d", nwe, PIX);
            end
         end
      end
      checks++;
      if (lg_ctrl[s + LINE_END + 1][1] !== 1'b0 || lg_ctrl[s + LINE_END + 2][5] !== 1'b1) begin
         errors++;
         $display("FAIL b2b_restart: got busy %b rog %b expected busy 0 then rog 1",
                  lg_ctrl[s + LINE_END + 1][1], lg_ctrl[s + LINE_END + 2][5]);
      end
      checks++;
      if (nwe != 2 * PIX || ndone != 2) begin
         errors++;
         $display("FAIL b2b_counts: got %0d writes %0d done expected %0d 2", nwe, ndone, 2 * PIX);
      end
   endtask

   task automatic test_reset_abort;
      int s, q0, nwe;
      logic [5:0] ex;
      dmode = 1; dconst = 11'h400;
      step(1'b0);
      step(1'b1); s = cur;
      for (int i = 1; i <= RS_OFF + 4 * PER; i++) step(1'b0);
      checks++;
      if (lg_ctrl[cur][2] !== 1'b1 || lg_addr[cur] !== 3'd3 || lg_data[cur] !== 11'h3f0) begin
         errors++;
         $display("FAIL abort_pre: got we %b addr %0d data %0h expected 1 3 3f0",
                  lg_ctrl[cur][2], lg_addr[cur], lg_data[cur]);
      end
      #1 RESET = 1'b1;
      #1;
      checks++;
      if ({rog_ccd, clk_ccd, clk_adc, pix_we, busy, line_done} !== 6'b0 ||
          pix_addr !== 3'd0 || pix_data !== 11'd0) begin
         errors++;
         $display("FAIL abort_async: got ctrl %b addr %0d data %0h expected 000000 0 0",
                  {rog_ccd, clk_ccd, clk_adc, pix_we, busy, line_done}, pix_addr, pix_data);
      end
      q0 = cur + 1;
      step(1'b0);
      step(1'b0);
      RESET = 1'b0;
      dmode = 0;
      for (int i = 0; i < 50; i++) step(1'b0);
      for (int c = q0; c <= cur; c++) begin
         checks++;
         if (lg_ctrl[c] !== 6'b0) begin
            errors++;
            $display("FAIL abort_quiet cyc %0d: got %b expected 000000", c - q0, lg_ctrl[c]);
         end
      end
      step(1'b1); s = cur;
      for (int i = 1; i <= LINE_END + 2; i++) step(1'b0);
      nwe = 0;
      for (int c = s; c <= s + LINE_END + 2; c++) begin
         ex = model_ctrl(c, s);
         checks++;
         if (lg_ctrl[c] !== ex) begin
            errors++;
            $display("FAIL abort_relaunch cyc+%0d: got %b expected %b", c - s, lg_ctrl[c], ex);
         end
         if (ex[2]) begin
            checks++;
            if (lg_addr[c] !== 3'(nwe) || lg_data[c] !== model_pix(drv[c-1])) begin
               errors++;
               $display("FAIL abort_write %0d: got addr %0d data %0h expected addr %0d data %0h",
                        nwe, lg_addr[c], lg_data[c], nwe, model_pix(drv[c-1]));
            end
            nwe++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_line_timing();
      test_saturation();
      test_random_data();
      test_back_to_back();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
